// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(16): message symbols pass through, then NPAR parity symbols.
// Optional macro RS_ENC_SHORTEN_EN adds in_last so a codeword can end before K message symbols.
`timescale 1ns/1ps
module rs_stream_encoder #(
    parameter int                  K    = 9,
    parameter int                  NPAR = 6,
    parameter logic [4*NPAR-1:0]   GEN  = 24'h793CAC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
`ifdef RS_ENC_SHORTEN_EN
    input  logic       in_last,
`endif
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       encoderBusy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam logic [3:0] K_LAST    = 4'(K - 1);
    localparam logic [3:0] NPAR_LAST = 4'(NPAR - 1);

    // GF(16) multiply, reduction by x^4 + x + 1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            p  = p ^ (b[i] ? aa : 4'h0);
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [NPAR-1:0][3:0]   r_q;
    logic                   rdy_en_q;
    logic                   out_valid_q;
    logic [3:0]             out_data_q;
    logic                   out_last_q;
    logic                   busy_q;

    logic [NPAR-1:0][3:0]   enc_d;
    logic [NPAR-1:0][3:0]   shift_d;
    logic [3:0]             fb_s;
    logic                   slot_free_s;
    logic                   out_fire_s;
    logic                   accept_s;
    logic                   msg_end_s;

    assign slot_free_s = !out_valid_q || out_ready;
    assign out_fire_s  = out_valid_q && out_ready;
    assign in_ready    = rdy_en_q && (state_q != ST_PAR) && slot_free_s;
    assign accept_s    = in_valid && in_ready;

`ifdef RS_ENC_SHORTEN_EN
    assign msg_end_s   = (cnt_q == K_LAST) || in_last;
`else
    assign msg_end_s   = (cnt_q == K_LAST);
`endif

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign encoderBusy = busy_q;

    // LFSR next state for an accepted symbol, and the plain upward shift used while emitting parity
    always_comb begin
        fb_s       = r_q[NPAR-1] ^ in_data;
        enc_d      = '0;
        shift_d    = '0;
        enc_d[0]   = gf_mul(fb_s, GEN[3:0]);
        shift_d[0] = 4'h0;
        for (int i = 1; i < NPAR; i++) begin
            enc_d[i]   = r_q[i-1] ^ gf_mul(fb_s, GEN[4*i +: 4]);
            shift_d[i] = r_q[i-1];
        end
    end

    // Control FSM, parity register and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'h0;
            r_q         <= '0;
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'h0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;

            case (state_q)
                ST_IDLE, ST_MSG: begin
                    if (accept_s) begin
                        r_q <= enc_d;
                        if (msg_end_s) begin
                            state_q <= ST_PAR;
                            cnt_q   <= 4'h0;
                        end else begin
                            state_q <= ST_MSG;
                            cnt_q   <= cnt_q + 4'h1;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_PAR: begin
                    // Leave PAR as r[0] is loaded so the next codeword can start while it drains
                    if (slot_free_s) begin
                        if (cnt_q == NPAR_LAST) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 4'h0;
                            r_q     <= '0;
                        end else begin
                            cnt_q   <= cnt_q + 4'h1;
                            r_q     <= shift_d;
                        end
                    end else begin
                        state_q <= ST_PAR;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'h0;
                    r_q     <= '0;
                end
            endcase

            if (accept_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
                out_last_q  <= 1'b0;
            end else if ((state_q == ST_PAR) && slot_free_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= r_q[NPAR-1];
                out_last_q  <= (cnt_q == NPAR_LAST);
            end else if (out_fire_s) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end

            if (accept_s) begin
                busy_q <= 1'b1;
            end else if (out_fire_s && out_last_q) begin
                busy_q <= 1'b0;
            end else begin
                busy_q <= busy_q;
            end
        end
    end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed self-checking bench for rs_stream_encoder with default parameters.
`timescale 1ns/1ps
module tb_rs_stream_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       encoderBusy;

    rs_stream_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
`ifdef RS_ENC_SHORTEN_EN
        .in_last     (in_last),
`endif
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .encoderBusy (encoderBusy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] stim [32];
    logic [3:0] exp_par [6];
    logic [4:0] outq [$];
    int         max_run;
    int         viol;
    bit         done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Feed n symbols from stim, capture transfers, stop after 'words' out_last transfers
    task automatic run_word(input int n, input int words, input bit tog, input int last_at);
        int idx;
        int lasts;
        int run;
        idx = 0; lasts = 0; run = 0; max_run = 0; viol = 0; done = 1'b0;
        outq.delete();
        for (int c = 0; c < 400; c++) begin
            out_ready = tog ? (c % 2 == 0) : 1'b1;
            in_valid  = (idx < n);
            in_data   = (idx < n) ? stim[idx] : 4'h0;
            in_last   = (idx == last_at);
            @(negedge clk);
            if (out_valid && out_ready) begin
                outq.push_back({out_last, out_data});
                if (out_last) lasts++;
            end
            if (out_valid && !out_ready && in_ready) viol++;
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (in_valid && in_ready) idx++;
            if (idx >= n && lasts >= words) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("run_complete", 32'(done), 32'd1);
    endtask

    // Compare captured stream: per codeword nmsg message symbols then exp_par, out_last on final parity
    task automatic check_stream(input string tag, input int nmsg, input int words);
        int         total;
        logic [4:0] obs;
        logic [4:0] expv;
        total = (nmsg + 6) * words;
        check({tag, "_count"}, 32'(outq.size()), 32'(total));
        for (int w = 0; w < words; w++) begin
            for (int i = 0; i < nmsg + 6; i++) begin
                obs  = ((w * (nmsg + 6) + i) < outq.size()) ? outq[w * (nmsg + 6) + i] : 5'h1F;
                expv = {(i == nmsg + 5) ? 1'b1 : 1'b0,
                        (i < nmsg) ? stim[w * nmsg + i] : exp_par[i - nmsg]};
                check($sformatf("%s_w%0d_s%0d", tag, w, i), 32'(obs), 32'(expv));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_data",  32'(out_data),    32'd0);
        check("rst_out_last",  32'(out_last),    32'd0);
        check("rst_busy",      32'(encoderBusy), 32'd0);
        check("rst_in_ready",  32'(in_ready),    32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // All-zero codeword: zero parity
        for (int i = 0; i < 32; i++) stim[i] = 4'h0;
        for (int i = 0; i < 6; i++) exp_par[i] = 4'h0;
        run_word(9, 1, 1'b0, -1);
        check_stream("zero", 9, 1);
        check("zero_busy_done", 32'(encoderBusy), 32'd0);

        // Eight zeros then 0x1: parity equals the generator coefficients
        exp_par = '{4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};
        stim[8] = 4'h1;
        run_word(9, 1, 1'b0, -1);
        check_stream("one", 9, 1);

        // Same stimulus, sink toggling ready
        run_word(9, 1, 1'b1, -1);
        check_stream("tog", 9, 1);
        check("tog_ready_violations", 32'(viol), 32'd0);

        // Partial codeword of four non-zero symbols, then reset
        begin
            int acc;
            acc = 0;
            for (int c = 0; c < 50 && acc < 4; c++) begin
                in_valid = 1'b1;
                in_data  = 4'(acc + 5);
                @(negedge clk);
                if (in_ready) acc++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("partial_accepted", 32'(acc), 32'd4);
            check("partial_busy", 32'(encoderBusy), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid),   32'd0);
        check("mid_rst_out_data",  32'(out_data),    32'd0);
        check("mid_rst_out_last",  32'(out_last),    32'd0);
        check("mid_rst_busy",      32'(encoderBusy), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_ready_after_rst", 32'(in_ready), 32'd1);
        run_word(9, 1, 1'b0, -1);
        check_stream("post_rst", 9, 1);

        // Two codewords back-to-back with no gap
        for (int i = 0; i < 9; i++) stim[9 + i] = stim[i];
        run_word(18, 2, 1'b0, -1);
        check_stream("b2b", 9, 2);
        check("b2b_valid_run", 32'(max_run), 32'd30);
        check("b2b_busy_done", 32'(encoderBusy), 32'd0);

`ifdef RS_ENC_SHORTEN_EN
        // Shortened codeword: 0,0,1 with in_last on the third symbol
        stim[0] = 4'h0; stim[1] = 4'h0; stim[2] = 4'h1;
        run_word(3, 1, 1'b0, 2);
        check_stream("short", 3, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
